// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU controller: op codes and FSM state type.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module alu_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               any_valid_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        any_valid_o = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (int'(rr_ptr_i) + k) % int'(NUM_REQ);
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o = 1'b1;
                grant_o     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin time-sharing of one ADD/SUB/AND/OR ALU between NUM_REQ requesters.
// Define ALU_SHARE_FLAGS_EN to add registered rsp_zero/rsp_carry outputs.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_result,
`ifdef ALU_SHARE_FLAGS_EN
    output logic                 rsp_zero,
    output logic                 rsp_carry,
`endif
    output logic                 busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [W-1:0]    res_q, res_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [W-1:0]    alu_res;
    logic [ID_W-1:0] pick;
    logic            any_valid;

    alu_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_i      (req_valid),
        .rr_ptr_i   (rr_ptr_q),
        .grant_o    (pick),
        .any_valid_o(any_valid)
    );

    always_comb begin
        alu_res = '0;
        unique case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q + ~b_q + W'(1);
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        gnt_d     = gnt_q;
        res_d     = res_q;
        id_d      = id_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    req_ready[pick] = 1'b1;
                    a_d     = req_a[int'(pick)*W +: W];
                    b_d     = req_b[int'(pick)*W +: W];
                    op_d    = req_op[int'(pick)*2 +: 2];
                    gnt_d   = pick;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d   = alu_res;
                id_d    = gnt_q;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    // NUM_REQ need not be a power of two, so wrap explicitly.
                    rr_ptr_d = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            gnt_q    <= '0;
            res_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            gnt_q    <= gnt_d;
            res_q    <= res_d;
            id_q     <= id_d;
        end
    end

    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign busy       = (state_q != StIdle);

`ifdef ALU_SHARE_FLAGS_EN
    logic zero_q, zero_d, carry_q, carry_d;

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (state_q == StExec) begin
            zero_d = (alu_res == '0);
            unique case (op_q)
                // Wrapped sum below an addend means the add carried out.
                OP_ADD:  carry_d = (alu_res < a_q);
                OP_SUB:  carry_d = (a_q < b_q);
                default: carry_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU/arbiter model.
// Build with ALU_SHARE_FLAGS_EN defined to also check the flag outputs.
module tb_alu_share_ctrl;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [W-1:0] rsp_result;
    logic         busy;
`ifdef ALU_SHARE_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_carry;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ptr = 0;

    alu_share_ctrl #(
        .NUM_REQ(N),
        .W      (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
`ifdef ALU_SHARE_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_alu(int a, int b, int op);
        case (op)
            0:       return (a + b) % (1 << W);
            1:       return (a - b + (1 << W)) % (1 << W);
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int model_carry(int a, int b, int op);
        if (op == 0) return (a + b >= (1 << W)) ? 1 : 0;
        if (op == 1) return (a < b) ? 1 : 0;
        return 0;
    endfunction

    function automatic int model_pick(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int id, input int a, input int b, input int op);
        req_valid[id]       = 1'b1;
        req_a[id*W +: W]    = W'(a);
        req_b[id*W +: W]    = W'(b);
        req_op[id*2 +: 2]   = 2'(op);
    endtask

    task automatic clr_req(input int id);
        req_valid[id] = 1'b0;
    endtask

    // Returns the granted index (lowest set ready bit) or -1 after the cycle budget.
    task automatic wait_grant(output int g);
        g = -1;
        for (int k = 0; k < 16 && g < 0; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            for (int i = N - 1; i >= 0; i--)
                if (req_ready[i]) g = i;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, busy, req_ready} !== '0)
            $display("FAIL reset_values: got valid=%0b id=%0d res=%0h busy=%0b ready=%b, want all 0",
                     rsp_valid, rsp_id, rsp_result, busy, req_ready);
        rst = 1'b0;
        exp_ptr = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b0)
            $display("FAIL idle_no_req: got busy=%0b ready=%b valid=%0b, want 0/0000/0",
                     busy, req_ready, rsp_valid);
    endtask

    task automatic test_single;
        int g;
        rsp_ready = 1'b1;
        set_req(0, 3, 5, 0);
        wait_grant(g);
        n_tests++;
        if (g != 0 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got ready=%b, want 0001", req_ready);
        end
        @(negedge clk);
        clr_req(0);
        #1;
        n_tests++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL single_exec: got busy=%0b valid=%0b ready=%b, want 1/0/0000",
                     busy, rsp_valid, req_ready);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'h8 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_rsp: got valid=%0b res=%0h id=%0d, want 1/8/0",
                     rsp_valid, rsp_result, rsp_id);
        end
        exp_ptr = 1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got valid=%0b busy=%0b, want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_alu_ops;
        int ta[5] = '{2, 9, 12, 12, 8};
        int tb[5] = '{3, 9, 10, 3, 8};
        int to[5] = '{1, 0, 2, 3, 0};
        int a, b, op, id, g, e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i < 5) begin
                a = ta[i]; b = tb[i]; op = to[i]; id = i % N;
            end else begin
                a = int'($urandom_range(15)); b = int'($urandom_range(15));
                op = int'($urandom_range(3)); id = int'($urandom_range(N - 1));
            end
            e = model_alu(a, b, op);
            set_req(id, a, b, op);
            wait_grant(g);
            n_tests++;
            if (g != id) begin
                n_fail++;
                $display("FAIL alu_grant[%0d]: got %0d, want %0d", i, g, id);
            end
            @(negedge clk);
            clr_req(id);
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== W'(e) || rsp_id !== 2'(id)) begin
                n_fail++;
                $display("FAIL alu_rsp[%0d] a=%0h b=%0h op=%0d: got valid=%0b res=%0h id=%0d, want 1/%0h/%0d",
                         i, a, b, op, rsp_valid, rsp_result, rsp_id, e, id);
            end
`ifdef ALU_SHARE_FLAGS_EN
            n_tests++;
            if (rsp_zero !== (e == 0) || rsp_carry !== 1'(model_carry(a, b, op))) begin
                n_fail++;
                $display("FAIL alu_flags[%0d] a=%0h b=%0h op=%0d: got z=%0b c=%0b, want z=%0b c=%0d",
                         i, a, b, op, rsp_zero, rsp_carry, e == 0, model_carry(a, b, op));
            end
`endif
            exp_ptr = (id + 1) % N;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int ca[N], cb[N];
        int g, gi, exp_g, e;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_ptr = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ca[i] = int'($urandom_range(15));
            cb[i] = int'($urandom_range(15));
            set_req(i, ca[i], cb[i], i);
        end
        for (int n = 0; n < 9; n++) begin
            exp_g = model_pick(req_valid, exp_ptr);
            wait_grant(g);
            n_tests++;
            if (g != exp_g || req_ready !== 4'(1 << exp_g)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got ready=%b, want grant %0d", n, req_ready, exp_g);
            end
            gi = (g < 0) ? 0 : g;
            e = model_alu(ca[gi], cb[gi], gi);
            @(negedge clk);
            ca[gi] = int'($urandom_range(15));
            cb[gi] = int'($urandom_range(15));
            set_req(gi, ca[gi], cb[gi], gi);
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== W'(e) || rsp_id !== 2'(gi)) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got valid=%0b res=%0h id=%0d, want 1/%0h/%0d",
                         n, rsp_valid, rsp_result, rsp_id, e, gi);
            end
            exp_ptr = (gi + 1) % N;
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int g, gi, exp_g, e, a0, b0, a2, b2;
        a0 = int'($urandom_range(15)); b0 = int'($urandom_range(15));
        a2 = int'($urandom_range(15)); b2 = int'($urandom_range(15));
        rsp_ready = 1'b0;
        set_req(0, a0, b0, 1);
        set_req(2, a2, b2, 3);
        exp_g = model_pick(req_valid, exp_ptr);
        wait_grant(g);
        n_tests++;
        if (g != exp_g) begin
            n_fail++;
            $display("FAIL bp_grant: got %0d, want %0d", g, exp_g);
        end
        gi = (g < 0) ? 0 : g;
        e = (gi == 0) ? model_alu(a0, b0, 1) : model_alu(a2, b2, 3);
        @(negedge clk);
        clr_req(gi);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== W'(e) || rsp_id !== 2'(gi)
                || req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%0b res=%0h id=%0d ready=%b busy=%0b, want 1/%0h/%0d/0000/1",
                         c, rsp_valid, rsp_result, rsp_id, req_ready, busy, e, gi);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        exp_ptr = (gi + 1) % N;
        exp_g = model_pick(req_valid, exp_ptr);
        wait_grant(g);
        n_tests++;
        if (g != exp_g || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got grant %0d valid=%0b, want grant %0d valid 0",
                     g, rsp_valid, exp_g);
        end
        gi = (g < 0) ? 0 : g;
        e = (gi == 0) ? model_alu(a0, b0, 1) : model_alu(a2, b2, 3);
        @(negedge clk);
        clr_req(gi);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== W'(e) || rsp_id !== 2'(gi)) begin
            n_fail++;
            $display("FAIL bp_next_rsp: got valid=%0b res=%0h id=%0d, want 1/%0h/%0d",
                     rsp_valid, rsp_result, rsp_id, e, gi);
        end
        exp_ptr = (gi + 1) % N;
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int g, gi, exp_g, e;
        int ra[N], rb[N];
        rsp_ready = 1'b1;
        // Complete one op on requester 2 so the pointer moves to 3.
        set_req(2, 7, 4, 0);
        wait_grant(g);
        @(negedge clk);
        clr_req(2);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 4'hB || rsp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rm_pre_rsp: got valid=%0b res=%0h id=%0d, want 1/b/2",
                     rsp_valid, rsp_result, rsp_id);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ra[i] = int'($urandom_range(15));
            rb[i] = int'($urandom_range(15));
        end
        set_req(2, ra[2], rb[2], 1);
        wait_grant(g);
        @(negedge clk);
        clr_req(2);
        rst = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL rm_async: got valid=%0b busy=%0b ready=%b, want 0/0/0000",
                     rsp_valid, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        set_req(1, ra[1], rb[1], 1);
        set_req(2, ra[2], rb[2], 1);
        set_req(3, ra[3], rb[3], 1);
        for (int n = 0; n < 3; n++) begin
            exp_g = model_pick(req_valid, exp_ptr);
            wait_grant(g);
            n_tests++;
            if (g != exp_g) begin
                n_fail++;
                $display("FAIL rm_grant[%0d]: got %0d, want %0d", n, g, exp_g);
            end
            gi = (g < 0) ? 1 : g;
            e = model_alu(ra[gi], rb[gi], 1);
            @(negedge clk);
            clr_req(gi);
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== W'(e) || rsp_id !== 2'(gi)) begin
                n_fail++;
                $display("FAIL rm_rsp[%0d]: got valid=%0b res=%0h id=%0d, want 1/%0h/%0d",
                         n, rsp_valid, rsp_result, rsp_id, e, gi);
            end
            exp_ptr = (gi + 1) % N;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_alu_ops;
        test_back_to_back;
        test_backpressure;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
